// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard tracker.
package hazard_pkg;

    // Default register address width; MAX_REG_AW bounds every tracked address.
    localparam int DEFAULT_REG_AW = 5;
    localparam int MAX_REG_AW     = 8;

    // One tracked pipeline stage: the in-flight writer it holds, if any.
    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] addr;
        logic                  is_load;
    } stage_t;

    // Width of a stage index; never narrower than one bit.
    function automatic int sel_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// One read port's view of the tracked stages: match vector, youngest-writer
// priority encode and load-use detection.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = sel_w(DEPTH)
) (
    input  logic [MAX_REG_AW-1:0] i_rd_addr,
    input  logic                  i_rd_en,
    input  stage_t [DEPTH-1:0]    i_stage,
    output logic                  o_fwd_valid,
    output logic [SEL_W-1:0]      o_fwd_sel,
    output logic                  o_load_use
);

    logic [DEPTH-1:0] w_hit;

    // Per-stage address match; register 0 is hard-wired and never forwards.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_hit = '0;
        for (int s = 0; s < DEPTH; s++) begin
            w_hit[s] = i_rd_en && i_stage[s].valid &&
                       (i_stage[s].addr == i_rd_addr) && (i_rd_addr != '0);
        end
    end

    // Priority encode towards the youngest stage and flag unready loads.
    always_comb begin
        o_fwd_valid = 1'b0;
        o_fwd_sel   = '0;
        o_load_use  = 1'b0;
        // Walk oldest to youngest so the lowest matching index wins.
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (w_hit[s]) begin
                o_fwd_valid = 1'b1;
                o_fwd_sel   = SEL_W'(s);
                if (i_stage[s].is_load && (s < LOAD_LAT)) begin
                    o_load_use = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Tracks in-flight register writers behind decode and reports, per read port,
// where to forward from and whether a load result is not yet available.
module pipe_hazard_tracker
    import hazard_pkg::*;
#(
    parameter int REG_AW   = DEFAULT_REG_AW,
    parameter int NUM_RD   = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           stalled,
    input  logic                           flush,
    input  logic [NUM_RD*REG_AW-1:0]       rd_addr,
    input  logic [NUM_RD-1:0]              rd_en,
    input  logic [REG_AW-1:0]              wr_addr,
    input  logic                           wr_en,
    input  logic                           wr_is_load,
    output logic [NUM_RD-1:0]              fwd_valid,
    output logic [NUM_RD*sel_w(DEPTH)-1:0] fwd_sel,
    output logic                           load_use_stall
);

    localparam int SEL_W = sel_w(DEPTH);

    stage_t [DEPTH-1:0] r_stage;
    stage_t             w_decode;
    logic [NUM_RD-1:0]  w_load_use;

    // Entry the decoding instruction would occupy; writes to r0 are not tracked.
    assign w_decode = '{valid:   wr_en && (wr_addr != '0),
                        addr:    MAX_REG_AW'(wr_addr),
                        is_load: wr_is_load};

    // Stage shift register: reset clears, en advances, stall/flush insert bubbles.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage
        // reads its neighbour's pre-edge value and the shift is order-independent.
        if (rst) begin
            r_stage <= '0;
        end else if (en) begin
            r_stage[0] <= (flush || stalled) ? stage_t'('0) : w_decode;
            for (int s = 1; s < DEPTH; s++) begin
                r_stage[s] <= (flush && (s == 1)) ? stage_t'('0) : r_stage[s-1];
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [MAX_REG_AW-1:0] w_rd_ext;
        assign w_rd_ext = MAX_REG_AW'(rd_addr[p*REG_AW +: REG_AW]);

        hazard_match #(
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SEL_W    (SEL_W)
        ) u_match (
            .i_rd_addr   (w_rd_ext),
            .i_rd_en     (rd_en[p]),
            .i_stage     (r_stage),
            .o_fwd_valid (fwd_valid[p]),
            .o_fwd_sel   (fwd_sel[p*SEL_W +: SEL_W]),
            .o_load_use  (w_load_use[p])
        );
    end

    assign load_use_stall = |w_load_use;

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Self-checking bench: directed scenarios followed by random traffic, both
// compared against a stage-list reference model of the tracker.
module tb_pipe_hazard_tracker;

    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int DEP   = 3;
    localparam int SW    = 2;

    logic            clk = 1'b0;
    logic            rst, en, stalled, flush;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD-1:0]  rd_en;
    logic [AW-1:0]   wr_addr;
    logic            wr_en, wr_is_load;
    logic [NRD-1:0]  fwd_valid, fwd_valid2;
    logic [NRD*SW-1:0] fwd_sel, fwd_sel2;
    logic            stall1, stall2;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a list of in-flight writers, index 0 youngest.
    bit m_v[DEP];
    int m_a[DEP];
    bit m_l[DEP];

    always #5 clk = ~clk;

    pipe_hazard_tracker #(.REG_AW(AW), .NUM_RD(NRD), .DEPTH(DEP), .LOAD_LAT(1)) dut (
        .clk(clk), .rst(rst), .en(en), .stalled(stalled), .flush(flush),
        .rd_addr(rd_addr), .rd_en(rd_en), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_is_load(wr_is_load), .fwd_valid(fwd_valid), .fwd_sel(fwd_sel),
        .load_use_stall(stall1)
    );

    pipe_hazard_tracker #(.REG_AW(AW), .NUM_RD(NRD), .DEPTH(DEP), .LOAD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .stalled(stalled), .flush(flush),
        .rd_addr(rd_addr), .rd_en(rd_en), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_is_load(wr_is_load), .fwd_valid(fwd_valid2), .fwd_sel(fwd_sel2),
        .load_use_stall(stall2)
    );

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the model retires/admits writers by the pipeline rules.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int s = 0; s < DEP; s++) begin m_v[s] = 0; m_a[s] = 0; m_l[s] = 0; end
        end else if (en) begin
            for (int s = DEP - 1; s >= 1; s--) begin
                m_v[s] = m_v[s-1]; m_a[s] = m_a[s-1]; m_l[s] = m_l[s-1];
            end
            if (flush) begin m_v[1] = 0; m_a[1] = 0; m_l[1] = 0; end
            if (flush || stalled) begin
                m_v[0] = 0; m_a[0] = 0; m_l[0] = 0;
            end else begin
                m_v[0] = wr_en && (wr_addr != 0); m_a[0] = int'(wr_addr); m_l[0] = wr_is_load;
            end
        end
        #1;
    endtask

    // Compare all outputs of both instances against the model.
    task automatic check(input string tag);
        bit ev;
        int es;
        bit st1, st2;
        int ra;
        #1;
        st1 = 0; st2 = 0;
        for (int p = 0; p < NRD; p++) begin
            ev = 0; es = 0;
            ra = int'(rd_addr[p*AW +: AW]);
            for (int s = 0; s < DEP; s++) begin
                if (rd_en[p] && m_v[s] && (m_a[s] == ra) && ra != 0) begin
                    if (!ev) begin ev = 1; es = s; end
                    if (m_l[s] && s < 1) st1 = 1;
                    if (m_l[s] && s < 2) st2 = 1;
                end
            end
            expect_eq($sformatf("%s fwd_valid[%0d]", tag, p), 32'(fwd_valid[p]), 32'(ev));
            expect_eq($sformatf("%s fwd_sel[%0d]", tag, p), 32'(fwd_sel[p*SW +: SW]), 32'(es));
            expect_eq($sformatf("%s lat2 fwd_valid[%0d]", tag, p), 32'(fwd_valid2[p]), 32'(ev));
            expect_eq($sformatf("%s lat2 fwd_sel[%0d]", tag, p), 32'(fwd_sel2[p*SW +: SW]), 32'(es));
        end
        expect_eq({tag, " load_use_stall"}, 32'(stall1), 32'(st1));
        expect_eq({tag, " lat2 load_use_stall"}, 32'(stall2), 32'(st2));
    endtask

    task automatic decode(input bit we, input int wa, input bit ld,
                          input int r0, input int r1, input logic [1:0] re);
        wr_en = we; wr_addr = AW'(wa); wr_is_load = ld;
        rd_addr = {AW'(r1), AW'(r0)}; rd_en = re;
    endtask

    initial begin
        for (int s = 0; s < DEP; s++) begin m_v[s] = 0; m_a[s] = 0; m_l[s] = 0; end
        rst = 1; en = 1; stalled = 0; flush = 0;
        decode(0, 0, 0, 0, 0, 2'b00);
        tick();
        rst = 0;

        // Reset then idle.
        decode(0, 0, 0, 5, 3, 2'b11);
        check("idle");
        expect_eq("idle literal fwd_valid", 32'(fwd_valid), 0);

        // ALU chain on r5.
        decode(1, 5, 0, 0, 0, 2'b00); tick();
        decode(0, 0, 0, 5, 0, 2'b01);
        check("alu c1");
        expect_eq("alu c1 literal valid", 32'(fwd_valid[0]), 1);
        expect_eq("alu c1 literal sel", 32'(fwd_sel[SW-1:0]), 0);
        tick(); check("alu c2");
        expect_eq("alu c2 literal sel", 32'(fwd_sel[SW-1:0]), 1);
        tick(); check("alu c3");
        tick(); check("alu c4");
        expect_eq("alu c4 literal valid", 32'(fwd_valid[0]), 0);

        // Youngest writer wins; r0 never forwards.
        decode(1, 7, 0, 0, 0, 2'b00); tick();
        decode(1, 7, 0, 0, 0, 2'b00); tick();
        decode(0, 0, 0, 7, 7, 2'b11); check("prio r7");
        expect_eq("prio literal sel1", 32'(fwd_sel[SW +: SW]), 0);
        decode(1, 0, 0, 0, 0, 2'b00); tick();
        decode(0, 0, 0, 0, 0, 2'b11); check("prio r0");

        // Load-use on port 1, resolved by a decode stall.
        decode(1, 9, 1, 0, 0, 2'b00); tick();
        decode(0, 0, 0, 0, 9, 2'b10); check("load c1");
        expect_eq("load c1 literal stall", 32'(stall1), 1);
        stalled = 1; tick(); stalled = 0;
        check("load c2");
        expect_eq("load c2 literal stall", 32'(stall1), 0);
        expect_eq("load c2 literal lat2 stall", 32'(stall2), 1);
        tick(); check("load c3");

        // Hold with en low.
        decode(1, 4, 0, 0, 0, 2'b00); tick();
        decode(0, 0, 0, 4, 0, 2'b01); en = 0;
        for (int i = 0; i < 3; i++) begin tick(); check("hold"); end
        en = 1;

        // Flush kills stage 0 and the decoding writer; stage 1 shifts to 2.
        decode(1, 2, 0, 0, 0, 2'b00); tick();
        decode(1, 4, 0, 0, 0, 2'b00); tick();
        decode(1, 6, 0, 0, 0, 2'b00); flush = 1; tick(); flush = 0;
        decode(0, 0, 0, 4, 6, 2'b11); check("flush killed");
        decode(0, 0, 0, 2, 2, 2'b11); check("flush shifted");
        expect_eq("flush literal sel", 32'(fwd_sel[SW-1:0]), 2);

        // Mid-run reset with every stage valid.
        decode(1, 1, 1, 0, 0, 2'b00); tick();
        decode(1, 2, 0, 0, 0, 2'b00); tick();
        decode(1, 3, 1, 0, 0, 2'b00); tick();
        decode(1, 8, 1, 0, 0, 2'b00); rst = 1; stalled = 1; flush = 1; tick();
        rst = 0; stalled = 0; flush = 0;
        decode(0, 0, 0, 1, 3, 2'b11); check("mid reset");
        expect_eq("mid reset literal valid", 32'(fwd_valid), 0);

        // Read enable gates a matching address.
        decode(1, 10, 0, 0, 0, 2'b00); tick();
        decode(0, 0, 0, 10, 10, 2'b00); check("rd_en off");
        decode(0, 0, 0, 10, 10, 2'b10); check("rd_en port1");

        // Random traffic over a small register range for frequent hits.
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 99) < 3);
            en      = ($urandom_range(0, 99) < 85);
            stalled = ($urandom_range(0, 99) < 20);
            flush   = ($urandom_range(0, 99) < 10);
            decode(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            check("random");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_tracker.md
PIPE_HAZARD_TRACKER -- requirements
Module: pipe_hazard_tracker

Interface
REQ-001 Parameters SHALL be: REG_AW, default 5, register address width; NUM_RD, default 2, read ports; DEPTH, default 3, tracked stages after decode (stage 0 youngest); LOAD_LAT, default 1, stages a load result is unavailable (1..DEPTH).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 en  in  1  pipeline advance enable; 0 holds all state.
REQ-006 stalled  in  1  decode stage held; a bubble enters stage 0.
REQ-007 flush  in  1  kill the decoding instruction and the stage-0 instruction.
REQ-008 rd_addr  in  NUM_RD*REG_AW  decode read addresses, port p at bits [p*REG_AW +: REG_AW].
REQ-009 rd_en  in  NUM_RD  port p actually reads its register.
REQ-010 wr_addr  in  REG_AW  decode destination register.
REQ-011 wr_en  in  1  decode instruction writes wr_addr.
REQ-012 wr_is_load  in  1  decode instruction is a load.
REQ-013 fwd_valid  out  NUM_RD  port p has a matching in-flight writer.
REQ-014 fwd_sel  out  NUM_RD*clog2(DEPTH)  stage index of the youngest matching writer per port.
REQ-015 load_use_stall  out  1  a read depends on an unready load result.

Function
REQ-016 Each stage s SHALL hold {valid, addr[REG_AW], is_load}.
REQ-017 When en=0, all entries SHALL hold.
REQ-018 When en=1, flush=0, stalled=0: stage 0 <= {wr_en && wr_addr!=0, wr_addr, wr_is_load}; stage s <= stage s-1 for s>=1.
REQ-019 When en=1, stalled=1, flush=0: stage 0 <= bubble (valid=0); stage s <= stage s-1 for s>=1.
REQ-020 When en=1, flush=1, regardless of stalled: stage 0 <= bubble; stage 1 <= bubble; stage s <= stage s-1 for s>=2.
REQ-021 Match hit[p][s] SHALL equal rd_en[p] && valid[s] && addr[s]==rd_addr[p]; register 0 never matches.
REQ-022 fwd_valid[p] SHALL be OR over s of hit[p][s]; fwd_sel[p] SHALL be the lowest s with hit[p][s], and 0 when fwd_valid[p]=0.
REQ-023 load_use_stall SHALL be 1 iff some p and some s<LOAD_LAT have hit[p][s] && is_load[s].
REQ-024 All outputs SHALL be combinational from current entries and decode inputs; zero-cycle latency; no path from stalled/flush/en to any output.
REQ-025 Writer leaves tracking after DEPTH advancing cycles; the oldest entry is discarded on shift.
REQ-026 Two ports matching the same stage SHALL both report it.

Reset
REQ-027 On rst=1 at a rising clk edge, all entries SHALL become invalid, addr=0, is_load=0, taking priority over en, stalled, flush.
REQ-028 While all entries are invalid: fwd_valid=0, fwd_sel=0, load_use_stall=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries within one cycle, with no partial shift.

Structure
REQ-030 Package hazard_pkg SHALL hold the default REG_AW, the stage-entry struct type, and a clog2-based SEL_W constant function.
REQ-031 Sub-module hazard_match SHALL implement one port's match vector and priority encode (REQ-021, REQ-022).
REQ-032 The top level SHALL instantiate NUM_RD hazard_match copies by generate loop.

Verification
REQ-033 Reset then idle: rd_addr={5,3}, rd_en=2'b11 -> fwd_valid=0, load_use_stall=0.
REQ-034 ALU chain: cycle0 wr r5 (wr_en=1, is_load=0); cycle1 rd port0=r5 -> fwd_valid[0]=1, fwd_sel[0]=0; cycle2 -> fwd_sel[0]=1; cycle4 -> fwd_valid[0]=0 (DEPTH=3).
REQ-035 Priority: write r7 in two consecutive cycles, then read r7 -> fwd_sel=0 (youngest); read r0 after writing r0 -> fwd_valid=0.
REQ-036 Load-use: load r9, next cycle read r9 on port1 -> load_use_stall=1; assert stalled -> next cycle load at stage 1, load_use_stall=0, fwd_sel[1]=1; with LOAD_LAT=2 the stall persists one more cycle.
REQ-037 Hold and flush: en=0 for 3 cycles -> fwd_sel unchanged; flush with r4 in stage 0 and r6 decoding -> neither matches next cycle, stage 2 receives the old stage-1 entry.
REQ-038 Mid-run reset with all three stages valid -> next cycle all fwd_valid=0, load_use_stall=0; rd_en[p]=0 -> fwd_valid[p]=0 despite matching address.
